fir_output_stage: RTL

- Downstream consumer of the FIR tap chain: takes the final accumulated y from the last tapped delay block and produces a fixed-point output sample.
- Captures y on each `ena` sample strobe.
- Rounds (half-up) and arithmetic-right-shifts the sample, then saturates it to the output width.
- Buffers results in a small FIFO and presents them on a valid/ready interface so the sink can stall without losing alignment with the filter.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/fir_sync_fifo.sv | 58 +++++
 rtl/fir_output_stage.sv | 87 ++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for FIR output taps: FIFO entry layout and the
// round-half-up / arithmetic-shift / saturate helper.
package fir_pkg;

    localparam int FIR_OUT_W = 16;

    typedef struct packed {
        logic                        sat;
        logic signed [FIR_OUT_W-1:0] data;
    } fir_entry_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } sat_result_t;

    // A 64-bit intermediate covers any N <= 63, so the rounding add can never wrap.
    function automatic sat_result_t sat_round(input logic signed [63:0] y,
                                              input int n,
                                              input int out_w,
                                              input int shift);
        logic signed [63:0] acc;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_result_t        r;
        acc = (y <<< (64 - n)) >>> (64 - n);
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        if (shift > 0) begin
            acc = acc + (64'sd1 <<< (shift - 1));
        end
        acc = acc >>> shift;
        if (acc > hi) begin
            r.sat   = 1'b1;
            r.value = hi;
        end else if (acc < lo) begin
            r.sat   = 1'b1;
            r.value = lo;
        end else begin
            r.sat   = 1'b0;
            r.value = acc;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is dropped unless a
// pop happens in the same cycle.
module fir_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: captures the accumulated sum, rounds/shifts/saturates it
// and buffers the results behind a valid/ready interface.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int N     = 32,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [N-1:0]               y_in,
    input  logic                       y_ready,
    output logic [OUT_W-1:0]           y_out,
    output logic                       y_valid,
    output logic                       sat_out,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    if (OUT_W != FIR_OUT_W || OUT_W > N || SHIFT < 0 || SHIFT >= N || N > 63 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("fir_output_stage: unsupported parameter combination");
    end

    logic signed [N-1:0] y_p1;
    logic                vld_p1;
    sat_result_t         sr_p1;
    fir_entry_t          entry_p1;
    fir_entry_t          head;
    logic                full;
    logic                empty;
    logic                pop;

    // Stage 1: capture the accumulator on the sample strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= ena;
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            y_p1 <= y_in;
        end
    end

    // Stage 2: round, shift and saturate in front of the FIFO write port.
    always_comb begin
        sr_p1         = sat_round(64'(y_p1), N, OUT_W, SHIFT);
        entry_p1.sat  = sr_p1.sat;
        entry_p1.data = OUT_W'(sr_p1.value);
    end

    assign pop = y_ready & ~empty;

    fir_sync_fifo #(
        .WIDTH($bits(fir_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (vld_p1),
        .pop  (pop),
        .din  (entry_p1),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (vld_p1 && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign y_out   = head.data;
    assign sat_out = head.sat;
    assign y_valid = ~empty;

endmodule
